alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Next-generation integer execute unit for the CPU datapath.
- Extends the combinational add/sub ALU with the full MIPS R-type logic/compare set, a registered result, and an iterative multiply/divide engine with HI/LO registers.
- Sits in the EX stage. The controller issues `start` with a funct-code opcode and waits on `done`.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, even).
- CNT_W, $clog2(WIDTH)+1, iteration-counter width (derived, not overridden).

Ports:
- clk     input   1        clock, all state on rising edge
- rst     input   1        synchronous active-high reset
- start   input   1        issue strobe, sampled only when busy=0
- in1     input   WIDTH    operand A (rs)
- in2     input   WIDTH    operand B (rt)
- opcode  input   6        MIPS funct code
- busy    output  1        multi-cycle operation in progress
- done    output  1        one-cycle pulse: result of accepted op is valid
- zero    output  1        (out == 0), combinational from out register
- out     output  WIDTH    registered ALU result
- hi      output  WIDTH    HI register (product upper half / remainder)
- lo      output  WIDTH    LO register (product lower half / quotient)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - out=0, hi=0, lo=0, busy=0, done=0, zero=1, FSM=IDLE, counter=0.
  - Reset during BUSY aborts the operation; no done pulse.
- Accept: at an edge with start=1 and busy=0. start while busy=1 is ignored with no queueing.
- Single-cycle ops: out is updated at the accepting edge, done=1 for the next cycle only, busy stays 0.
  - 100000 add, 100001 addu: in1+in2, wraps mod 2^WIDTH, no overflow flag.
  - 100010 sub, 100011 subu: in1-in2, wraps.
  - 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101010 slt: signed compare. 101011 sltu: unsigned compare. Result is 1 or 0, zero-extended.
  - 010000 mfhi: out=hi. 010010 mflo: out=lo.
  - Any other code: out=0, done pulse.
- Multi-cycle ops leave out unchanged:
  - 011000 mult (signed), 011001 multu.
  - 011010 div (signed), 011011 divu.
- FSM states IDLE, BUSY, FIX:
  - IDLE→BUSY on accept. Operand magnitudes are latched (two's-complement absolute value for signed ops). Result signs are latched: product and quotient sign = in1[MSB]^in2[MSB]; remainder sign = in1[MSB].
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle, WIDTH cycles.
  - FIX: apply sign correction and write hi/lo, then go to IDLE. busy falls and done=1 for one cycle.
- Latency: accept at edge E0 → busy=1 from E0 to E(WIDTH+1) → hi/lo valid and done=1 after E(WIDTH+1). That is WIDTH+1 cycles; 33 for WIDTH=32.
- Product: {hi,lo} = full 2·WIDTH-bit product.
- Divide: lo=quotient truncated toward zero, hi=remainder with the dividend's sign.
- Divide by zero (in2=0):
  - Detected at accept, no iteration.
  - Goes straight to FIX: lo = all ones, hi = in1, done after 1 cycle, busy high for 1 cycle.
- Signed MIN/−1: lo=MIN (wraps), hi=0.
- hi/lo hold their values until the next mult/div completes or reset.
- zero tracks out only. It is not affected by hi/lo.
- start in the same cycle that done=1 is accepted normally (back-to-back issue).

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: mult/multu/div/divu are supported as above.
- Undefined:
  - No iterative engine is built. hi and lo are tied to 0, busy is tied to 0.
  - Opcodes 011000–011011 behave as unknown: out=0, single-cycle done.
  - mfhi/mflo return 0.

Test Plan:
- Reset then add in1=5, in2=7 → after 1 clk out=12, done=1 for 1 cycle, zero=0. Then sub 7−7 → out=0, zero=1.
- slt in1=0xFFFFFFFF, in2=1 → out=1. sltu with same operands → out=0. Opcode 111111 → out=0, done pulse.
- mult in1=−3, in2=7 → busy for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB. multu 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE. mflo → out=0xFFFFFFFE.
- div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 → lo=14, hi=2. div 0x80000000/−1 → lo=0x80000000, hi=0.
- div 9/0 → done after 1 cycle, lo=0xFFFFFFFF, hi=9. start pulsed while busy on a mult → ignored, result unchanged.
- Assert rst at cycle 10 of a mult → hi=lo=0, busy=0, no done pulse. Build without ALU_MULDIV_EN: mult → out=0, single-cycle done, hi=lo=0.

Source files
------------

// File: rtl/alu_muldiv.sv
// EX-stage integer unit: registered single-cycle ALU plus iterative mult/div with HI/LO.
// The iterative engine is built only when ALU_MULDIV_EN is defined; otherwise hi/lo/busy are 0.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [5:0]       opcode,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_ADDU = 6'b100001;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_SUBU = 6'b100011;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTU = 6'b101011;
  localparam logic [5:0] OP_MFHI = 6'b010000;
  localparam logic [5:0] OP_MFLO = 6'b010010;

  logic             accept;
  logic             is_muldiv;
  logic             fix_now;
  logic [WIDTH-1:0] alu_res;

  assign accept = start & ~busy;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD, OP_ADDU: alu_res = in1 + in2;
      OP_SUB, OP_SUBU: alu_res = in1 - in2;
      OP_AND:          alu_res = in1 & in2;
      OP_OR:           alu_res = in1 | in2;
      OP_XOR:          alu_res = in1 ^ in2;
      OP_NOR:          alu_res = ~(in1 | in2);
      OP_SLT:          alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU:         alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_MFHI:         alu_res = hi;
      OP_MFLO:         alu_res = lo;
      default:         alu_res = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= '0;
      done <= 1'b0;
    end else begin
      if (accept && !is_muldiv) out <= alu_res;
      done <= (accept && !is_muldiv) || fix_now;
    end
  end

  assign zero = (out == '0);

`ifdef ALU_MULDIV_EN

  typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             is_div;
  logic             div0;
  logic             neg_q;
  logic             neg_r;

  logic             signed_op;
  logic             div_by_zero;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  assign is_muldiv   = (opcode[5:2] == 4'b0110);
  assign signed_op   = ~opcode[0];
  assign div_by_zero = opcode[1] && (in2 == '0);
  assign mag1        = (signed_op && in1[WIDTH-1]) ? -in1 : in1;
  assign mag2        = (signed_op && in2[WIDTH-1]) ? -in2 : in2;

  assign busy    = (state_q != IDLE);
  assign fix_now = (state_q == FIX);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_muldiv) state_d = div_by_zero ? FIX : BUSY;
      BUSY:    if (cnt == CNT_W'(1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration: shift-add on {acc_hi,acc_lo} for multiply, restoring subtract for divide.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_fit;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_fit   = (div_shift >= {1'b0, opnd});
    if (is_div) begin
      step_hi = div_fit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_fit};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    prod   = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (div0) begin
      fix_hi = acc_lo;
      fix_lo = '1;
    end else if (is_div) begin
      fix_hi = neg_r ? -acc_hi : acc_hi;
      fix_lo = neg_q ? -acc_lo : acc_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && is_muldiv) begin
            is_div <= opcode[1];
            div0   <= div_by_zero;
            neg_q  <= signed_op && (in1[WIDTH-1] ^ in2[WIDTH-1]);
            neg_r  <= signed_op && in1[WIDTH-1];
            cnt    <= CNT_W'(WIDTH);
            acc_hi <= '0;
            if (opcode[1]) begin
              // Divide by zero keeps the raw dividend so FIX can return it in hi.
              opnd   <= mag2;
              acc_lo <= div_by_zero ? in1 : mag1;
            end else begin
              opnd   <= mag1;
              acc_lo <= mag2;
            end
          end
        end
        BUSY: begin
          cnt    <= cnt - CNT_W'(1);
          acc_hi <= step_hi;
          acc_lo <= step_lo;
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

`else

  assign is_muldiv = 1'b0;
  assign fix_now   = 1'b0;
  assign busy      = 1'b0;
  assign hi        = '0;
  assign lo        = '0;

`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed cases plus randomized ops against an arithmetic model.
// Exercises the iterative engine only when ALU_MULDIV_EN is defined for the build.
module tb_alu_muldiv;

  localparam int W = 32;

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_ADDU = 6'b100001;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_SUBU = 6'b100011;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTU = 6'b101011;
  localparam logic [5:0] OP_MFHI = 6'b010000;
  localparam logic [5:0] OP_MFLO = 6'b010010;
  localparam logic [5:0] OP_MULT = 6'b011000;
  localparam logic [5:0] OP_MULU = 6'b011001;
  localparam logic [5:0] OP_DIV  = 6'b011010;
  localparam logic [5:0] OP_DIVU = 6'b011011;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [5:0]   opcode;
  logic         busy;
  logic         done;
  logic         zero;
  logic [W-1:0] out;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] m_out = '0;
  logic [W-1:0] m_hi  = '0;
  logic [W-1:0] m_lo  = '0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .in1    (in1),
    .in2    (in2),
    .opcode (opcode),
    .busy   (busy),
    .done   (done),
    .zero   (zero),
    .out    (out),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_md(input logic [5:0] op);
`ifdef ALU_MULDIV_EN
    return (op == OP_MULT) || (op == OP_MULU) || (op == OP_DIV) || (op == OP_DIVU);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] ref_single(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_ADD, OP_ADDU: return a + b;
      OP_SUB, OP_SUBU: return a - b;
      OP_AND:          return a & b;
      OP_OR:           return a | b;
      OP_XOR:          return a ^ b;
      OP_NOR:          return ~(a | b);
      OP_SLT:          return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU:         return (a < b) ? 32'd1 : 32'd0;
      OP_MFHI:         return m_hi;
      OP_MFLO:         return m_lo;
      default:         return 32'd0;
    endcase
  endfunction

  task automatic ref_muldiv(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] eh, output logic [W-1:0] el, output int lat);
    longint          p, q, r;
    longint unsigned up, ua, ub;
    lat = W + 1;
    eh  = '0;
    el  = '0;
    case (op)
      OP_MULT: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        eh = p[63:32];
        el = p[31:0];
      end
      OP_MULU: begin
        ua = {32'd0, a};
        ub = {32'd0, b};
        up = ua * ub;
        eh = up[63:32];
        el = up[31:0];
      end
      default: begin
        if (b == '0) begin
          eh  = a;
          el  = '1;
          lat = 1;
        end else if (op == OP_DIV) begin
          q  = longint'($signed(a)) / longint'($signed(b));
          r  = longint'($signed(a)) % longint'($signed(b));
          eh = r[31:0];
          el = q[31:0];
        end else begin
          eh = a % b;
          el = a / b;
        end
      end
    endcase
  endtask

  task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start  = 1'b1;
    opcode = op;
    in1    = a;
    in2    = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic run_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] eo, eh, el;
    int           lat, n;
    bit           busy_ok;
    if (is_md(op)) begin
      ref_muldiv(op, a, b, eh, el, lat);
      issue(op, a, b);
      n       = 0;
      busy_ok = 1'b1;
      while (done !== 1'b1 && n < 200) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        @(posedge clk);
        #1;
        n++;
      end
      check({tag, " latency"}, 64'(n), 64'(lat));
      check({tag, " busy held"}, 64'(busy_ok), 64'd1);
      check({tag, " busy end"}, 64'(busy), 64'd0);
      check({tag, " hi"}, 64'(hi), 64'(eh));
      check({tag, " lo"}, 64'(lo), 64'(el));
      check({tag, " out kept"}, 64'(out), 64'(m_out));
      m_hi = eh;
      m_lo = el;
    end else begin
      eo = ref_single(op, a, b);
      issue(op, a, b);
      check({tag, " out"}, 64'(out), 64'(eo));
      check({tag, " done"}, 64'(done), 64'd1);
      check({tag, " busy"}, 64'(busy), 64'd0);
      check({tag, " zero"}, 64'(zero), 64'(eo == '0));
      check({tag, " hi kept"}, 64'(hi), 64'(m_hi));
      check({tag, " lo kept"}, 64'(lo), 64'(m_lo));
      m_out = eo;
    end
    @(posedge clk);
    #1;
    check({tag, " done drop"}, 64'(done), 64'd0);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, 15));
      1:       return 32'h0 - 32'($urandom_range(0, 15));
      2:       return 32'h8000_0000 | 32'($urandom_range(0, 3));
      default: return 32'($urandom);
    endcase
  endfunction

  logic [5:0] op_pool [16] = '{OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
                               OP_SLT, OP_SLTU, OP_MFHI, OP_MFLO, OP_MULT, OP_MULU, OP_DIV, OP_DIVU};

  initial begin
    logic [5:0]   op;
    logic [W-1:0] a, b;
    int           n, pulses;

    rst    = 1'b1;
    start  = 1'b0;
    in1    = '0;
    in2    = '0;
    opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out", 64'(out), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset zero", 64'(zero), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    run_op(OP_ADD, 32'd5, 32'd7, "add 5+7");
    run_op(OP_SUB, 32'd7, 32'd7, "sub 7-7");
    run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, "slt -1<1");
    run_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1, "sltu");
    run_op(6'b111111, 32'd3, 32'd4, "unknown op");
    run_op(OP_NOR, 32'h0F0F_0000, 32'h0000_00FF, "nor");

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult -3*7");
    run_op(OP_MULU, 32'hFFFF_FFFF, 32'd2, "multu");
    run_op(OP_MFLO, 32'd0, 32'd0, "mflo");
    run_op(OP_MFHI, 32'd0, 32'd0, "mfhi");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    run_op(OP_DIVU, 32'd100, 32'd7, "divu 100/7");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
    run_op(OP_DIV, 32'd9, 32'd0, "div 9/0");
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, "divu max/1");

    // Back-to-back: second start lands in the cycle where done=1.
    issue(OP_ADD, 32'd5, 32'd7);
    check("b2b first done", 64'(done), 64'd1);
    issue(OP_SUB, 32'd20, 32'd3);
    check("b2b second out", 64'(out), 64'd17);
    check("b2b second done", 64'(done), 64'd1);
    m_out = 32'd17;

`ifdef ALU_MULDIV_EN
    // start while busy is ignored.
    issue(OP_MULT, 32'd6, 32'd5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start  = 1'b1;
    opcode = OP_ADD;
    in1    = 32'd1;
    in2    = 32'd1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    n      = 6;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ignored start latency", 64'(n), 64'(W + 1));
    check("ignored start lo", 64'(lo), 64'd30);
    check("ignored start hi", 64'(hi), 64'd0);
    check("ignored start out", 64'(out), 64'(m_out));
    @(posedge clk);
    #1;
    check("ignored start no extra done", 64'(done), 64'd0);
    m_hi = '0;
    m_lo = 32'd30;

    // Reset during BUSY aborts with no done pulse.
    issue(OP_MULT, 32'd123, 32'd456);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    check("abort out", 64'(out), 64'd0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    check("abort no done", 64'(pulses), 64'd0);
    m_hi  = '0;
    m_lo  = '0;
    m_out = '0;
`endif

    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 15)];
      a  = rnd_operand();
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = a;
        default: b = rnd_operand();
      endcase
      run_op(op, a, b, $sformatf("rnd%0d op%b", i, op));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
